// File: rtl/multi_edge_qualifier.sv
// Multi-channel input conditioner: synchroniser chain, programmable glitch
// filter, registered edge strobes, sticky event flags and an aggregated irq.
module multi_edge_qualifier #(
  parameter int   CHANNELS      = 4,
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_WIDTH  = 8,
  parameter logic DEFAULT_LEVEL = 1'b0
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [CHANNELS-1:0]     ch_in,
  input  logic [FILTER_WIDTH-1:0] filter_len,
  input  logic [2*CHANNELS-1:0]   edge_mode,
  input  logic [CHANNELS-1:0]     flag_clr,
  output logic [CHANNELS-1:0]     level_out,
  output logic [CHANNELS-1:0]     pos_edge,
  output logic [CHANNELS-1:0]     neg_edge,
  output logic [CHANNELS-1:0]     event_flag,
  output logic                    irq
);

  logic [CHANNELS-1:0]     sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]     sync;
  logic [FILTER_WIDTH-1:0] cnt [CHANNELS];
  logic [FILTER_WIDTH:0]   cnt_inc [CHANNELS];
  logic [FILTER_WIDTH-1:0] len_eff;
  logic [CHANNELS-1:0]     toggle;
  logic [CHANNELS-1:0]     rise;
  logic [CHANNELS-1:0]     fall;
  logic [CHANNELS-1:0]     flag_set;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign len_eff = (filter_len == '0) ? FILTER_WIDTH'(1) : filter_len;

  // Comparison is done one bit wider so cnt+1 cannot wrap at the top of the range.
  always_comb begin
    toggle   = '0;
    rise     = '0;
    fall     = '0;
    flag_set = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_inc[i]  = {1'b0, cnt[i]} + {{FILTER_WIDTH{1'b0}}, 1'b1};
      toggle[i]   = (sync[i] != level_out[i]) && (cnt_inc[i] >= {1'b0, len_eff});
      rise[i]     = toggle[i] && !level_out[i];
      fall[i]     = toggle[i] &&  level_out[i];
      flag_set[i] = (rise[i] && edge_mode[2*i]) || (fall[i] && edge_mode[2*i+1]);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= {CHANNELS{DEFAULT_LEVEL}};
      end
    end else begin
      sync_q[0] <= ch_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
      level_out <= {CHANNELS{DEFAULT_LEVEL}};
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (toggle[i] || (sync[i] == level_out[i])) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt_inc[i][FILTER_WIDTH-1:0];
        end
      end
      level_out <= level_out ^ toggle;
    end
  end

  // A set in the same cycle as a clear wins, so no edge is ever lost.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pos_edge   <= '0;
      neg_edge   <= '0;
      event_flag <= '0;
      irq        <= 1'b0;
    end else begin
      pos_edge   <= rise;
      neg_edge   <= fall;
      event_flag <= flag_set | (event_flag & ~flag_clr);
      irq        <= |event_flag;
    end
  end

endmodule

// File: doc/multi_edge_qualifier.md
# multi_edge_qualifier

Multi-channel input conditioner that synchronises asynchronous pins, rejects glitches with a runtime-programmable digital filter, and produces single-cycle rising/falling edge pulses plus per-channel sticky event flags. It sits between raw FPGA inputs (encoder, fault, hall and trigger lines) and the control logic, which consumes clean levels, edge strobes and one aggregated interrupt line.

## Interface
- CHANNELS, 4, number of independent input channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)
- FILTER_WIDTH, 8, width of per-channel filter counter and of filter_len
- DEFAULT_LEVEL, 1'b0, reset value of synchroniser flops and qualified levels
- clk  in  1  system clock
- nrst  in  1  reset, asynchronous, active-low
- ch_in  in  CHANNELS  raw asynchronous inputs
- filter_len  in  FILTER_WIDTH  required consecutive stable samples (0 treated as 1), shared by all channels
- edge_mode  in  2*CHANNELS  per channel [2i+1:2i]: 00 none, 01 rising, 10 falling, 11 both
- flag_clr  in  CHANNELS  per-channel sticky flag clear, one-cycle strobe
- level_out  out  CHANNELS  qualified (filtered) level
- pos_edge  out  CHANNELS  one-cycle pulse on qualified 0->1
- neg_edge  out  CHANNELS  one-cycle pulse on qualified 1->0
- event_flag  out  CHANNELS  sticky flag, set by edges selected in edge_mode
- irq  out  1  registered OR of event_flag

## Operation
- Per channel, independent: synchroniser chain -> filter -> edge/flag logic.
- Synchroniser: SYNC_STAGES flops, output sync[i].
- Filter: state = level_out[i], counter cnt[i] (FILTER_WIDTH bits).
  - sync[i] == level_out[i]: cnt <= 0.
  - sync[i] != level_out[i] and cnt+1 >= L (L = max(filter_len,1)): level_out toggles, cnt <= 0.
  - otherwise cnt <= cnt+1. cnt never exceeds L-1; no wrap possible.
- Any sample matching level_out restarts qualification (glitch shorter than L samples produces no output change).
- filter_len change takes effect on the next clock; if cnt+1 already ≥ new L, toggle occurs on next differing sample.
- pos_edge[i]/neg_edge[i]: registered, asserted on the same clock edge that level_out toggles, high exactly one cycle. Never both high together.
- event_flag[i] set on clock where (pos_edge-condition and edge_mode bit0) or (neg_edge-condition and edge_mode bit1). Cleared by flag_clr[i]. Simultaneous set and clear: set wins. edge_mode = 00 blocks setting; existing flag retained.
- irq <= |event_flag (one cycle behind flags).

## Timing
- Reset (nrst low, asynchronous): sync flops and level_out = DEFAULT_LEVEL; cnt = 0; pos_edge, neg_edge, event_flag, irq = 0.
- Reset release: no edge pulses generated from reset state regardless of ch_in level until qualification completes.
- Latency, stable step on ch_in to level_out/edge pulse: SYNC_STAGES + L clocks (±1 for async sampling).
- Edge to event_flag: same cycle as pulse (flag updated on same edge). Edge to irq: +1 clock.
- Reset mid-qualification: counter and partial progress discarded; no pulse emitted.
- Input toggling faster than L samples: level_out frozen, no pulses.

## Test plan
- Reset with DEFAULT_LEVEL=0, ch_in=4'hF held, filter_len=3: outputs 0 during reset; after release pos_edge=4'hF exactly one cycle at clock 2+3=5, level_out=4'hF thereafter.
- Glitch reject: filter_len=4, ch_in[0] high for 3 clocks then low -> no pos_edge[0], level_out[0]=0; high for 4 clocks -> one pos_edge[0].
- filter_len=0: behaves as 1; 1-cycle-wide synced pulse yields pos_edge then neg_edge on consecutive transitions.
- Edge modes: edge_mode=8'b11_10_01_00, toggle all channels 0->1->0: event_flag ends 4'b1110 with ch1 set only on rise, ch2 only on fall; irq=1 one clock after first flag.
- flag_clr[1] asserted in the same cycle as a new pos_edge[1] with mode 01: event_flag[1] stays 1; clear in a later quiet cycle -> 0, irq drops one clock later if no other flags.
- Assert nrst mid-qualification (cnt=2 of L=5): no pulse, level_out returns to DEFAULT_LEVEL, full L samples required after release.
